simple_restoring_div_16by8: RTL

Sequential radix-2 restoring divider, the inverse of the 8x8 unsigned multiplier path. Takes a 2·DW-bit unsigned dividend and a DW-bit unsigned divisor and returns a DW-bit quotient and DW-bit remainder after DW iteration cycles. Used in the modular-arithmetic datapath to recover operands and reduce small products. Flags divide-by-zero and quotient overflow. Valid/ready handshakes on both sides.

---
 rtl/simple_restoring_div_16by8_pkg.sv | 22 ++
 rtl/simple_restoring_div_16by8_if.sv | 34 +++
 rtl/simple_restoring_div_16by8_step.sv | 30 +++
 rtl/simple_restoring_div_16by8.sv | 126 ++++++++++++
 4 files changed

// File: rtl/simple_restoring_div_16by8_pkg.sv
// ---------------------------------------------------------------------------
// simple_restoring_div_16by8_pkg
// Shared definitions for the sequential restoring divider:
//   - DW_DEFAULT : default quotient/remainder/divisor width (dividend is 2*DW)
//   - S_IDLE/S_CALC/S_DONE : state encodings
//   - state_t    : FSM state type built from those encodings
// ---------------------------------------------------------------------------
package simple_restoring_div_16by8_pkg;

    localparam int DW_DEFAULT = 8;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = S_IDLE,
        ST_CALC = S_CALC,
        ST_DONE = S_DONE
    } state_t;

endpackage

// File: rtl/simple_restoring_div_16by8_if.sv
// ---------------------------------------------------------------------------
// simple_restoring_div_16by8_if
// Operand and result handshakes of the divider.
//   in_valid/in_ready   : operand handshake (dividend 2*DW, divisor DW)
//   out_valid/out_ready : result handshake (quotient, remainder, err_dz, err_ovf)
// master : operand producer / result consumer
// slave  : the divider
// ---------------------------------------------------------------------------
interface simple_restoring_div_16by8_if
    import simple_restoring_div_16by8_pkg::*;
#(
    parameter int DW = DW_DEFAULT
);
    logic            in_valid;
    logic            in_ready;
    logic [2*DW-1:0] dividend;
    logic [DW-1:0]   divisor;
    logic            out_valid;
    logic            out_ready;
    logic [DW-1:0]   quotient;
    logic [DW-1:0]   remainder;
    logic            err_dz;
    logic            err_ovf;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, err_dz, err_ovf
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, err_dz, err_ovf
    );
endinterface

// File: rtl/simple_restoring_div_16by8_step.sv
// ---------------------------------------------------------------------------
// simple_div_step
// Combinational conditional-subtract cell of a radix-2 restoring divider.
//   i_r       : partial remainder (always < i_divisor on entry)
//   i_bit     : next dividend bit shifted in
//   i_divisor : divisor
//   o_r       : new partial remainder
//   o_qbit    : quotient bit produced by this step
// ---------------------------------------------------------------------------
module simple_div_step
    import simple_restoring_div_16by8_pkg::*;
#(
    parameter int DW = DW_DEFAULT
) (
    input  logic [DW-1:0] i_r,
    input  logic          i_bit,
    input  logic [DW-1:0] i_divisor,
    output logic [DW-1:0] o_r,
    output logic          o_qbit
);
    logic [DW:0] w_t;

    always_comb begin
        w_t    = {i_r, i_bit};
        o_qbit = (w_t >= {1'b0, i_divisor});
        // The true result is below the divisor, so it fits in DW bits and a
        // modulo-2^DW subtraction on the low bits yields it exactly.
        o_r    = o_qbit ? (w_t[DW-1:0] - i_divisor) : w_t[DW-1:0];
    end
endmodule

// File: rtl/simple_restoring_div_16by8.sv
// ---------------------------------------------------------------------------
// simple_restoring_div_16by8
// Sequential radix-2 restoring divider: 2*DW-bit unsigned dividend by DW-bit
// unsigned divisor, DW iteration cycles, DW-bit quotient and remainder.
// Divide-by-zero and quotient overflow are detected at accept time and
// answered immediately with quotient = all ones, remainder = 0.
//   clk    : clock, rising edge
//   rst    : synchronous active-high reset
//   io_bus : operand/result handshakes (slave side)
// ---------------------------------------------------------------------------
module simple_restoring_div_16by8
    import simple_restoring_div_16by8_pkg::*;
#(
    parameter int DW = DW_DEFAULT
) (
    input  logic                          clk,
    input  logic                          rst,
    simple_restoring_div_16by8_if.slave   io_bus
);
    localparam int            CNT_W    = (DW > 1) ? $clog2(DW) : 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DW - 1);
    localparam logic [DW-1:0] ALL_ONES = '1;

    state_t           r_state;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [DW-1:0]    r_div;
    logic [DW-1:0]    r_rem;
    logic [DW-1:0]    r_quo;
    logic [CNT_W-1:0] r_cnt;
    logic             r_err_dz;
    logic             r_err_ovf;

    logic [DW-1:0]    w_rem_next;
    logic             w_qbit;
    logic [DW-1:0]    w_hi;
    logic [DW-1:0]    w_lo;

    assign w_hi = io_bus.dividend[2*DW-1:DW];
    assign w_lo = io_bus.dividend[DW-1:0];

    // The quotient register doubles as the shift register of pending
    // dividend bits: its MSB is the next bit fed to the step cell.
    simple_div_step #(.DW(DW)) u_step (
        .i_r       (r_rem),
        .i_bit     (r_quo[DW-1]),
        .i_divisor (r_div),
        .o_r       (w_rem_next),
        .o_qbit    (w_qbit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_div       <= '0;
            r_rem       <= '0;
            r_quo       <= '0;
            r_cnt       <= '0;
            r_err_dz    <= 1'b0;
            r_err_ovf   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_in_ready <= 1'b1;
                    if (io_bus.in_valid && r_in_ready) begin
                        r_in_ready <= 1'b0;
                        r_div      <= io_bus.divisor;
                        r_rem      <= w_hi;
                        r_quo      <= w_lo;
                        r_cnt      <= '0;
                        r_err_dz   <= 1'b0;
                        r_err_ovf  <= 1'b0;
                        if (io_bus.divisor == '0) begin
                            r_err_dz    <= 1'b1;
                            r_quo       <= ALL_ONES;
                            r_rem       <= '0;
                            r_out_valid <= 1'b1;
                            r_state     <= ST_DONE;
                        end else if (w_hi >= io_bus.divisor) begin
                            r_err_ovf   <= 1'b1;
                            r_quo       <= ALL_ONES;
                            r_rem       <= '0;
                            r_out_valid <= 1'b1;
                            r_state     <= ST_DONE;
                        end else begin
                            r_state <= ST_CALC;
                        end
                    end
                end

                ST_CALC: begin
                    r_rem <= w_rem_next;
                    r_quo <= {r_quo[DW-2:0], w_qbit};
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == LAST_STEP) begin
                        r_out_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end
                end

                ST_DONE: begin
                    if (io_bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end

                default: begin
                    r_in_ready  <= 1'b0;
                    r_out_valid <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign io_bus.in_ready  = r_in_ready;
    assign io_bus.out_valid = r_out_valid;
    assign io_bus.quotient  = r_quo;
    assign io_bus.remainder = r_rem;
    assign io_bus.err_dz    = r_err_dz;
    assign io_bus.err_ovf   = r_err_ovf;
endmodule
